// File: rtl/ibex_pext_accum_pkg.sv
// Shared P-extension types: accumulate op codes, FSM states and saturation bounds.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ibex_pkg_pext;

    typedef enum logic [2:0] {
        ACC_SUM2  = 3'd0,
        ACC_DIFF2 = 3'd1,
        ACC_SUB2  = 3'd2,
        ACC_ONE   = 3'd3,
        ACC_NEG   = 3'd4
    } pext_acc_op_e;

    typedef enum logic [1:0] {
        ACC_ST_IDLE  = 2'd0,
        ACC_ST_ACCUM = 2'd1,
        ACC_ST_DONE  = 2'd2
    } pext_acc_state_e;

    localparam logic signed [33:0] PEXT_SAT_MAX32 = 34'sh0_7FFF_FFFF;
    localparam logic signed [33:0] PEXT_SAT_MIN32 = 34'sh3_8000_0000;

    typedef struct packed {
        logic neg0;
        logic neg1;
        logic p1_en;
    } pext_acc_ctl_t;

    // Reserved codes fall into the default arm and behave like ACC_ONE.
    function automatic pext_acc_ctl_t pext_acc_decode(input pext_acc_op_e op);
        pext_acc_ctl_t ctl;
        ctl = '{neg0: 1'b0, neg1: 1'b0, p1_en: 1'b0};
        case (op)
            ACC_SUM2:  ctl = '{neg0: 1'b0, neg1: 1'b0, p1_en: 1'b1};
            ACC_DIFF2: ctl = '{neg0: 1'b0, neg1: 1'b1, p1_en: 1'b1};
            ACC_SUB2:  ctl = '{neg0: 1'b1, neg1: 1'b1, p1_en: 1'b1};
            ACC_NEG:   ctl = '{neg0: 1'b1, neg1: 1'b0, p1_en: 1'b0};
            default:   ctl = '{neg0: 1'b0, neg1: 1'b0, p1_en: 1'b0};
        endcase
        return ctl;
    endfunction

endpackage

// File: rtl/ibex_pext_accum_if.sv
// Beat/result bundle between the P-extension multiplier and the accumulate back end.
// Latency: n/a (wiring only).
// Backpressure: beat_ready from the accumulator gates beat_valid from the multiplier.
interface ibex_pext_accum_if;
    import ibex_pkg_pext::*;

    logic         flush;
    pext_acc_op_e op;
    logic [31:0]  rd_val;
    logic         beat_valid;
    logic         beat_last;
    logic         beat_ready;
    logic [31:0]  prod0;
    logic [31:0]  prod1;
    logic         result_valid;
    logic [31:0]  result;
    logic         ov;

    modport master (
        output flush, op, rd_val, beat_valid, beat_last, prod0, prod1,
        input  beat_ready, result_valid, result, ov
    );

    modport slave (
        input  flush, op, rd_val, beat_valid, beat_last, prod0, prod1,
        output beat_ready, result_valid, result, ov
    );

endinterface

// File: rtl/ibex_pext_sat_add.sv
// One accumulate step: base +/- p0 +/- p1 at 34 bits, then clamp to signed-32 or wrap mod 2^32.
// Latency: purely combinational.
// Backpressure: none.
module ibex_pext_sat_add
    import ibex_pkg_pext::*;
(
    input  logic signed [33:0] base,
    input  logic        [31:0] prod0,
    input  logic        [31:0] prod1,
    input  logic               neg0,
    input  logic               neg1,
    input  logic               p1_en,
    input  logic               sat_en,
    output logic signed [33:0] sum,
    output logic               clamp
);

    logic signed [33:0] term0;
    logic signed [33:0] term1;
    logic signed [33:0] raw;

    // Two guard bits keep base + two signed-32 terms exact, even for -(-2^31).
    always_comb begin
        term0 = {{2{prod0[31]}}, prod0};
        term1 = '0;
        if (neg0) begin
            term0 = -term0;
        end
        if (p1_en) begin
            term1 = neg1 ? -{{2{prod1[31]}}, prod1} : {{2{prod1[31]}}, prod1};
        end
        raw   = base + term0 + term1;
        sum   = raw;
        clamp = 1'b0;
        if (sat_en) begin
            if (raw > PEXT_SAT_MAX32) begin
                sum   = PEXT_SAT_MAX32;
                clamp = 1'b1;
            end else if (raw < PEXT_SAT_MIN32) begin
                sum   = PEXT_SAT_MIN32;
                clamp = 1'b1;
            end
        end else begin
            sum = {{2{raw[31]}}, raw[31:0]};
        end
    end

endmodule

// File: rtl/ibex_pext_accum.sv
// Accumulate/saturate back end for P-extension MAC ops; IBEX_PEXT_ACC_SAT_EN enables clamping and ov.
// Latency: result_valid one cycle after the last accepted beat.
// Backpressure: beat_ready low only during the single DONE cycle (1-cycle bubble between ops).
module ibex_pext_accum
    import ibex_pkg_pext::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    ibex_pext_accum_if.slave        acc_if
);

`ifdef IBEX_PEXT_ACC_SAT_EN
    localparam logic SatEn = 1'b1;
`else
    localparam logic SatEn = 1'b0;
`endif

    pext_acc_state_e    state_q, state_d;
    pext_acc_op_e       op_q, op_eff;
    pext_acc_ctl_t      ctl;
    logic signed [33:0] acc_q;
    logic signed [33:0] base;
    logic signed [33:0] sum;
    logic        [31:0] result_q;
    logic               sat_clamp;
    logic               in_idle;
    logic               in_done;
    logic               accept;
    logic               beat_ready;
    logic               result_valid;

    assign in_idle = (state_q == ACC_ST_IDLE);
    assign in_done = (state_q == ACC_ST_DONE);
    // A beat coinciding with flush is dropped, so it never reaches the datapath.
    assign accept  = acc_if.beat_valid & ~in_done & ~acc_if.flush;

    // The first beat seeds from rd_val/op_i; later beats use the running state.
    assign base   = in_idle ? {{2{acc_if.rd_val[31]}}, acc_if.rd_val} : acc_q;
    assign op_eff = in_idle ? acc_if.op : op_q;
    assign ctl    = pext_acc_decode(op_eff);

    ibex_pext_sat_add u_sat_add (
        .base   (base),
        .prod0  (acc_if.prod0),
        .prod1  (acc_if.prod1),
        .neg0   (ctl.neg0),
        .neg1   (ctl.neg1),
        .p1_en  (ctl.p1_en),
        .sat_en (SatEn),
        .sum    (sum),
        .clamp  (sat_clamp)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ACC_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        beat_ready   = 1'b1;
        result_valid = 1'b0;
        case (state_q)
            ACC_ST_IDLE, ACC_ST_ACCUM: begin
                if (accept) begin
                    state_d = acc_if.beat_last ? ACC_ST_DONE : ACC_ST_ACCUM;
                end
            end
            ACC_ST_DONE: begin
                beat_ready   = 1'b0;
                result_valid = 1'b1;
                state_d      = ACC_ST_IDLE;
            end
            default: state_d = ACC_ST_IDLE;
        endcase
        if (acc_if.flush) begin
            state_d      = ACC_ST_IDLE;
            result_valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            op_q     <= ACC_SUM2;
            result_q <= '0;
        end else if (accept) begin
            acc_q <= sum;
            if (in_idle) begin
                op_q <= acc_if.op;
            end
            if (acc_if.beat_last) begin
                result_q <= sum[31:0];
            end
        end
    end

`ifdef IBEX_PEXT_ACC_SAT_EN
    logic ov_q;

    // Sticky across beats; a fresh op starts clean on its first beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ov_q <= 1'b0;
        end else if (acc_if.flush) begin
            ov_q <= 1'b0;
        end else if (accept) begin
            ov_q <= (in_idle ? 1'b0 : ov_q) | sat_clamp;
        end
    end

    assign acc_if.ov = result_valid & ov_q;
`else
    logic unused_sat_clamp;
    assign unused_sat_clamp = sat_clamp;
    assign acc_if.ov        = 1'b0;
`endif

    assign acc_if.beat_ready   = beat_ready;
    assign acc_if.result_valid = result_valid;
    assign acc_if.result       = result_q;

endmodule

// File: tb/tb_ibex_pext_accum.sv
// Bench for ibex_pext_accum: directed cases plus random multi-beat ops against an arithmetic model.
module tb_ibex_pext_accum;
    import ibex_pkg_pext::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ibex_pext_accum_if bus();

    ibex_pext_accum dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .acc_if (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic signed [31:0] bp0 [8];
    logic signed [31:0] bp1 [8];
    logic [31:0] last_res;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit integer arithmetic, clamp or wrap after every beat.
    function automatic void model(input int op, input logic [31:0] rd, input int nb,
                                  output logic [31:0] res, output logic ov);
        logic signed [31:0] r;
        longint a, t0, t1;
        r  = rd;
        a  = longint'(r);
        ov = 1'b0;
        for (int b = 0; b < nb; b++) begin
            t0 = longint'(bp0[b]);
            t1 = longint'(bp1[b]);
            case (op)
                0:       a = a + t0 + t1;
                1:       a = a + t0 - t1;
                2:       a = a - t0 - t1;
                4:       a = a - t0;
                default: a = a + t0;
            endcase
`ifdef IBEX_PEXT_ACC_SAT_EN
            if (a > 64'sd2147483647) begin
                a  = 64'sd2147483647;
                ov = 1'b1;
            end else if (a < -64'sd2147483648) begin
                a  = -64'sd2147483648;
                ov = 1'b1;
            end
`else
            r = a[31:0];
            a = longint'(r);
`endif
        end
        res = a[31:0];
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] rd, input int nb,
                          input bit use_exp, input logic [31:0] exp_res, input logic exp_ov,
                          input bit rnd);
        logic [31:0] m_res;
        logic        m_ov;
        int          waited;
        model(int'(op), rd, nb, m_res, m_ov);
        if (use_exp) begin
            m_res = exp_res;
            m_ov  = exp_ov;
        end
        waited = 0;
        while (!bus.beat_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check_val("ready_before_op", 32'(bus.beat_ready), 32'd1);
        for (int b = 0; b < nb; b++) begin
            if (rnd && b > 0) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.beat_valid = 1'b0;
                    bus.op         = pext_acc_op_e'($urandom_range(0, 7));
                    bus.rd_val     = $urandom;
                    @(negedge clk);
                    check_val("gap_no_valid", 32'(bus.result_valid), 32'd0);
                end
            end
            bus.beat_valid = 1'b1;
            bus.beat_last  = (b == nb - 1);
            bus.prod0      = bp0[b];
            bus.prod1      = bp1[b];
            if (b == 0) begin
                bus.op     = pext_acc_op_e'(op);
                bus.rd_val = rd;
            end else if (rnd) begin
                bus.op     = pext_acc_op_e'($urandom_range(0, 7));
                bus.rd_val = $urandom;
            end else begin
                bus.op     = ACC_NEG;
                bus.rd_val = 32'd999;
            end
            @(negedge clk);
            if (b != nb - 1) check_val("no_early_valid", 32'(bus.result_valid), 32'd0);
        end
        bus.beat_valid = 1'b0;
        bus.beat_last  = 1'b0;
        check_val("result_valid", 32'(bus.result_valid), 32'd1);
        check_val("ready_low_done", 32'(bus.beat_ready), 32'd0);
        check_val("result", bus.result, m_res);
        check_val("ov", 32'(bus.ov), 32'(m_ov));
        @(negedge clk);
        check_val("valid_one_cycle", 32'(bus.result_valid), 32'd0);
        check_val("ov_outside_valid", 32'(bus.ov), 32'd0);
        check_val("result_held", bus.result, m_res);
        check_val("ready_after_done", 32'(bus.beat_ready), 32'd1);
        last_res = m_res;
    endtask

    task automatic set_beat(input int b, input logic [31:0] p0, input logic [31:0] p1);
        bp0[b] = p0;
        bp1[b] = p1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.flush      = 1'b0;
        bus.op         = ACC_SUM2;
        bus.rd_val     = '0;
        bus.beat_valid = 1'b0;
        bus.beat_last  = 1'b0;
        bus.prod0      = '0;
        bus.prod1      = '0;
        last_res       = '0;
        #2;
        check_val("rst_ready", 32'(bus.beat_ready), 32'd1);
        check_val("rst_valid", 32'(bus.result_valid), 32'd0);
        check_val("rst_result", bus.result, 32'd0);
        check_val("rst_ov", 32'(bus.ov), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        set_beat(0, 32'd3, 32'd4);
        run_op(3'(ACC_SUM2), 32'd10, 1, 1'b1, 32'd17, 1'b0, 1'b0);

        set_beat(0, 32'h10, 32'h0);
`ifdef IBEX_PEXT_ACC_SAT_EN
        run_op(3'(ACC_SUM2), 32'h7FFF_FFF0, 1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
`else
        run_op(3'(ACC_SUM2), 32'h7FFF_FFF0, 1, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
`endif

        set_beat(0, 32'd1, 32'd1);
`ifdef IBEX_PEXT_ACC_SAT_EN
        run_op(3'(ACC_SUB2), 32'h8000_0000, 1, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
`else
        run_op(3'(ACC_SUB2), 32'h8000_0000, 1, 1'b1, 32'h7FFF_FFFE, 1'b0, 1'b0);
`endif

        set_beat(0, 32'd100, 32'd0);
        set_beat(1, -32'sd5, 32'd0);
        run_op(3'(ACC_ONE), 32'd5, 2, 1'b1, 32'd100, 1'b0, 1'b0);

        set_beat(0, 32'd1, 32'd0);
        set_beat(1, -32'sd1, 32'd0);
`ifdef IBEX_PEXT_ACC_SAT_EN
        run_op(3'(ACC_ONE), 32'h7FFF_FFFF, 2, 1'b1, 32'h7FFF_FFFE, 1'b1, 1'b0);
`else
        run_op(3'(ACC_ONE), 32'h7FFF_FFFF, 2, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0);
`endif

        // Flush mid-operation, with a competing last beat that must be dropped.
        bus.beat_valid = 1'b1;
        bus.beat_last  = 1'b0;
        bus.op         = ACC_SUM2;
        bus.rd_val     = 32'd1;
        bus.prod0      = 32'd50;
        bus.prod1      = 32'd60;
        @(negedge clk);
        check_val("flush_pre_valid", 32'(bus.result_valid), 32'd0);
        bus.flush     = 1'b1;
        bus.beat_last = 1'b1;
        bus.prod0     = 32'd77;
        @(negedge clk);
        check_val("flush_no_valid", 32'(bus.result_valid), 32'd0);
        check_val("flush_result_kept", bus.result, last_res);
        check_val("flush_ready", 32'(bus.beat_ready), 32'd1);
        bus.flush      = 1'b0;
        bus.beat_valid = 1'b0;
        bus.beat_last  = 1'b0;
        @(negedge clk);
        check_val("flush_idle_valid", 32'(bus.result_valid), 32'd0);
        set_beat(0, 32'd2, 32'd0);
        run_op(3'(ACC_NEG), 32'd7, 1, 1'b1, 32'd5, 1'b0, 1'b0);

        // Flush landing in DONE suppresses the strobe but keeps the loaded result.
        bus.beat_valid = 1'b1;
        bus.beat_last  = 1'b1;
        bus.op         = ACC_SUM2;
        bus.rd_val     = 32'h7FFF_FFFF;
        bus.prod0      = 32'd5;
        bus.prod1      = 32'd5;
        @(negedge clk);
        bus.beat_valid = 1'b0;
        bus.beat_last  = 1'b0;
        bus.flush      = 1'b1;
        #1;
        check_val("flush_done_valid", 32'(bus.result_valid), 32'd0);
        check_val("flush_done_ov", 32'(bus.ov), 32'd0);
`ifdef IBEX_PEXT_ACC_SAT_EN
        check_val("flush_done_result", bus.result, 32'h7FFF_FFFF);
`else
        check_val("flush_done_result", bus.result, 32'h8000_0009);
`endif
        @(negedge clk);
        bus.flush = 1'b0;
        check_val("flush_done_ready", 32'(bus.beat_ready), 32'd1);
        check_val("flush_done_idle", 32'(bus.result_valid), 32'd0);

        for (int t = 0; t < 60; t++) begin
            int nb;
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_beat(b, $urandom, $urandom);
                end else begin
                    set_beat(b, 32'($urandom_range(0, 2000)) - 32'd1000,
                                32'($urandom_range(0, 2000)) - 32'd1000);
                end
            end
            run_op(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 32'h7FFF_FF00 + 32'($urandom_range(0, 255)) : $urandom,
                   nb, 1'b0, 32'd0, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ibex_pext_accum.md
# ibex_pext_accum

Accumulate and saturate back end for the P-extension multiplier. It accepts product beats over a valid/ready handshake and, on the first beat, seeds a 34-bit signed accumulator with the destination register value. Each beat's products are added or subtracted with optional signed-32 saturation. One cycle after the last beat it presents the final 32-bit result and the overflow flag. It sits between the P-extension multiplier and the ALU/writeback path and performs the accumulate step for the MAC ops: KMADA, KMADS, KMSDA, KMABB-class, KMMAC and KMMSB.

## Interface
Parameters: none.

Ports:
- `clk_i` input 1: core clock.
- `rst_ni` input 1: reset. One clock; reset is asynchronous and active-low.
- `flush_i` input 1: abort the current operation. Highest priority.
- `op_i` input 3 (`pext_acc_op_e`): accumulate operation. Sampled on the first accepted beat only.
- `rd_val_i` input 32: initial accumulator value. Sampled on the first accepted beat only.
- `beat_valid_i` input 1: a product beat is present.
- `beat_last_i` input 1: the current beat is the final beat of the operation.
- `beat_ready_o` output 1: the unit can accept a beat.
- `prod0_i` input 32: signed product, lane 0.
- `prod1_i` input 32: signed product, lane 1.
- `result_valid_o` output 1: single-cycle result strobe.
- `result_o` output 32: final accumulated value. Registered.
- `ov_o` output 1: saturation occurred during the operation. Meaningful only while `result_valid_o` is high.

## Operation
- Operations (`pext_acc_op_e`):
  - `ACC_SUM2`: base + p0 + p1
  - `ACC_DIFF2`: base + p0 − p1
  - `ACC_SUB2`: base − p0 − p1
  - `ACC_ONE`: base + p0
  - `ACC_NEG`: base − p0
  - Codes 5–7 are reserved and behave as `ACC_ONE`.
- A beat is accepted when `beat_valid_i` and `beat_ready_o` are both high.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `beat_ready_o` = 1.
  - On an accepted beat: base = sign-extended `rd_val_i`; latch `op_i` into an internal op register; clear the sticky ov flag.
  - Next state: DONE if `beat_last_i`, else ACCUM.
  - With no beat, the state stays IDLE.
- ACCUM:
  - `beat_ready_o` = 1.
  - On an accepted beat: base = current accumulator; the latched op is used. `op_i` and `rd_val_i` are ignored.
  - Next state: DONE if `beat_last_i`, else ACCUM.
  - Idle cycles hold all state.
- DONE:
  - `result_valid_o` = 1.
  - `beat_ready_o` = 0.
  - Next state: IDLE unconditionally.
- Per-beat arithmetic:
  - s = base + (±sext34(p0)) + (±sext34(p1)), evaluated at 34 bits. This width cannot overflow.
  - p1 contributes 0 for `ACC_ONE` and `ACC_NEG`.
- Saturation: s is clamped to [0x8000_0000, 0x7FFF_FFFF] after every beat, not only at the end. Any clamp sets the sticky ov flag.
- `result_o` is loaded with accumulator[31:0] on entry to DONE. It holds its value until the next DONE.
- `flush_i` in any state:
  - The next state is IDLE and the sticky ov flag is cleared.
  - No `result_valid_o` is produced. A flush asserted in DONE suppresses that cycle's `result_valid_o`.
  - `result_o` is retained.
  - A beat presented in the same cycle as `flush_i` is discarded.
- Reset values:
  - state = IDLE, accumulator = 0, op register = `ACC_SUM2`, ov flag = 0.
  - `result_o` = 0, `result_valid_o` = 0, `ov_o` = 0, `beat_ready_o` = 1.

## Timing
- Latency: if the last beat is accepted in cycle N, `result_valid_o` and `result_o` are valid in cycle N+1.
- Single-beat operation: 2 cycles. Two-beat operation (32x32): 3 cycles.
- `beat_ready_o` drops for exactly the DONE cycle. Back-to-back operations therefore have a 1-cycle bubble.
- `beat_ready_o` depends only on state, never combinationally on `beat_valid_i`.
- `ov_o` is asserted only together with `result_valid_o`. It is 0 at all other times.

## Configuration
- Macro: `IBEX_PEXT_ACC_SAT_EN`.
- Defined: clamping and the sticky ov flag behave as described in Operation.
- Undefined:
  - Each beat's s is truncated to 32 bits and sign-extended back, i.e. modulo 2^32 wrap.
  - `ov_o` is tied to 0 and the ov flag register is removed.

## Structure
- `pext_acc_op_e` (3-bit) is added to the shared `ibex_pkg_pext` package.
- The saturation bounds `PEXT_SAT_MAX32` and `PEXT_SAT_MIN32` are constants in that same package.
- The per-beat arithmetic lives in one combinational sub-module, `ibex_pext_sat_add`:
  - Inputs: 34-bit base, two 32-bit products, sign controls, a p1 enable, and the saturation enable.
  - Outputs: the 34-bit value and a clamp flag.
- The FSM, accumulator and output registers stay in `ibex_pext_accum`.

## Test plan
- `ACC_SUM2` single beat, rd=10, p0=3, p1=4 → `result_o`=17, `ov_o`=0, valid exactly 1 cycle after the beat. `beat_ready_o`=0 in that cycle.
- `ACC_SUM2`, rd=0x7FFF_FFF0, p0=0x10, p1=0 → 0x7FFF_FFFF, `ov_o`=1. With the macro undefined → 0x8000_0000, `ov_o`=0.
- `ACC_SUB2`, rd=0x8000_0000, p0=1, p1=1 → 0x8000_0000, `ov_o`=1.
- `ACC_ONE` two beats, rd=5:
  - Beat 0: p0=100.
  - Beat 1: p0=−5, last. Drive rd_val=999 and op=`ACC_NEG` on this beat; both are ignored.
  - Result 100, valid 1 cycle after beat 1.
- `ACC_ONE` two beats, rd=0x7FFF_FFFF, beat 0 p0=+1, beat 1 p0=−1 → 0x7FFF_FFFE, `ov_o`=1. This checks intermediate saturation.
- `flush_i` pulsed in ACCUM after beat 0 → no `result_valid_o`, `result_o` unchanged. A following single-beat `ACC_NEG` with rd=7, p0=2 → 5, `ov_o`=0.
